pc_gen: RTL and testbench

Parametrised fetch-stage program counter for the pipelined MIPS core. It replaces the plain enable-gated PC register.
- Arbitrates between sequential advance, branch/jump redirect, exception entry and ERET return.
- Holds a redirect that arrives during a stall until the stall clears.
- Flags misaligned or out-of-text fetch addresses for the exception unit.
- Sits between the NPC/CP0 logic and IM/IF-ID.

---
 rtl/pc_gen_pkg.sv | 15 +
 rtl/pc_gen_if.sv | 25 ++
 rtl/pc_gen_hist_buf.sv | 31 +++
 rtl/pc_gen.sv | 111 +++++++++++
 tb/tb_pc_gen.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator: FSM encoding and default vectors.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
  localparam logic [31:0] DEF_TEXT_LO   = 32'h0000_3000;
  localparam logic [31:0] DEF_TEXT_HI   = 32'h0000_6FFC;

endpackage

// File: rtl/pc_gen_if.sv
// Redirect/fetch bundle between the NPC/CP0 logic (master) and the PC generator (slave).
interface pc_gen_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stall;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_target;
  logic              exc_valid;
  logic              eret_valid;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              fetch_adel;
  logic              redir_pending;

  modport master (
    output stall, redir_valid, redir_target, exc_valid, eret_valid, epc,
    input  pc, pc_valid, fetch_adel, redir_pending
  );

  modport slave (
    input  stall, redir_valid, redir_target, exc_valid, eret_valid, epc,
    output pc, pc_valid, fetch_adel, redir_pending
  );
endinterface

// File: rtl/pc_gen_hist_buf.sv
// pc_hist_buf: circular buffer of recent fetch PCs; rd_idx=0 returns the newest entry.
module pc_hist_buf #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] rd_data
);
  logic [ADDR_W-1:0] mem_r [DEPTH];
  logic [IDX_W-1:0]  wp_r;

  // Storage and write pointer; pointer wraps naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
      wp_r <= '0;
    end else if (wr_en) begin
      mem_r[wp_r] <= wr_data;
      wp_r        <= wp_r + IDX_W'(1);
    end
  end

  assign rd_data = mem_r[wp_r - IDX_W'(1) - rd_idx];
endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator with held redirects and fetch address-error flag.
// Optional history buffer enabled by defining PC_HIST_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(DEF_EXC_VEC),
  parameter logic [ADDR_W-1:0] TEXT_LO    = ADDR_W'(DEF_TEXT_LO),
  parameter logic [ADDR_W-1:0] TEXT_HI    = ADDR_W'(DEF_TEXT_HI),
  parameter int unsigned       INC        = 4
`ifdef PC_HIST_EN
  ,
  parameter int unsigned       HIST_DEPTH = 8
`endif
) (
  input  logic clk,
  input  logic reset,
  pc_gen_if.slave bus
`ifdef PC_HIST_EN
  ,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [ADDR_W-1:0]             hist_pc
`endif
);
  pc_state_e         state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [ADDR_W-1:0] tgt_r, tgt_s;
  logic              pc_valid_r, pc_valid_s;
  logic              pend_r;

  // State, PC and pending-target registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_BOOT;
      pc_r       <= RESET_VEC;
      tgt_r      <= '0;
      pc_valid_r <= 1'b0;
      pend_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      tgt_r      <= tgt_s;
      pc_valid_r <= pc_valid_s;
      pend_r     <= (state_s == ST_HOLD);
    end
  end

  // Next-PC arbitration: exception > ERET > redirect > stall > pending release > sequential.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    tgt_s      = tgt_r;
    pc_valid_s = pc_valid_r;
    case (state_r)
      ST_BOOT: begin
        state_s    = ST_RUN;
        pc_valid_s = 1'b1;
      end
      ST_RUN, ST_HOLD: begin
        if (bus.exc_valid) begin
          pc_s    = EXC_VEC;
          tgt_s   = '0;
          state_s = ST_RUN;
        end else if (bus.eret_valid) begin
          pc_s    = bus.epc;
          tgt_s   = '0;
          state_s = ST_RUN;
        end else if (bus.redir_valid) begin
          if (bus.stall) begin
            tgt_s   = bus.redir_target;
            state_s = ST_HOLD;
          end else begin
            pc_s    = bus.redir_target;
            state_s = ST_RUN;
          end
        end else if (bus.stall) begin
          pc_s = pc_r;
        end else if (state_r == ST_HOLD) begin
          pc_s    = tgt_r;
          state_s = ST_RUN;
        end else begin
          pc_s = pc_r + ADDR_W'(INC);
        end
      end
      default: begin
        state_s    = ST_BOOT;
        pc_valid_s = 1'b0;
      end
    endcase
  end

  assign bus.pc            = pc_r;
  assign bus.pc_valid      = pc_valid_r;
  assign bus.redir_pending = pend_r;
  assign bus.fetch_adel    = pc_valid_r & ((pc_r[1:0] != 2'b00) | (pc_r < TEXT_LO) | (pc_r > TEXT_HI));

`ifdef PC_HIST_EN
  pc_hist_buf #(
    .ADDR_W (ADDR_W),
    .DEPTH  (HIST_DEPTH)
  ) u_hist (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pc_valid_r & (pc_s != pc_r)),
    .wr_data (pc_s),
    .rd_idx  (hist_idx),
    .rd_data (hist_pc)
  );
`endif
endmodule

// File: tb/tb_pc_gen.sv
// Randomized self-checking bench for pc_gen against a behavioural next-PC model.
module tb_pc_gen;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_W(AW)) bus ();

`ifdef PC_HIST_EN
  logic [2:0]    hist_idx;
  logic [AW-1:0] hist_pc;
`endif

  pc_gen #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef PC_HIST_EN
    ,
    .hist_idx (hist_idx),
    .hist_pc  (hist_pc)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_boot;
  logic        m_pend;
  logic [31:0] m_tgt;
  logic [31:0] m_hist [8];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [31:0] npc;
    if (reset) begin
      m_pc = 32'h0000_3000; m_valid = 1'b0; m_boot = 1'b1; m_pend = 1'b0; m_tgt = 32'h0;
      for (int i = 0; i < 8; i++) m_hist[i] = 32'h0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_valid = 1'b1;
    end else begin
      npc = m_pc;
      if (bus.exc_valid) begin
        npc = 32'h0000_4180; m_pend = 1'b0;
      end else if (bus.eret_valid) begin
        npc = bus.epc; m_pend = 1'b0;
      end else if (bus.redir_valid && bus.stall) begin
        m_pend = 1'b1; m_tgt = bus.redir_target;
      end else if (bus.redir_valid) begin
        npc = bus.redir_target; m_pend = 1'b0;
      end else if (bus.stall) begin
        npc = m_pc;
      end else if (m_pend) begin
        npc = m_tgt; m_pend = 1'b0;
      end else begin
        npc = m_pc + 32'd4;
      end
      if (m_valid && npc != m_pc) begin
        for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = npc;
      end
      m_pc = npc;
    end
  endtask

  function automatic logic exp_adel();
    return m_valid && ((m_pc % 32'd4) != 32'd0 || m_pc < 32'h0000_3000 || m_pc > 32'h0000_6FFC);
  endfunction

  task automatic compare_all();
    check_eq("pc", bus.pc, m_pc);
    check_eq("pc_valid", 32'(bus.pc_valid), 32'(m_valid));
    check_eq("redir_pending", 32'(bus.redir_pending), 32'(m_pend));
    check_eq("fetch_adel", 32'(bus.fetch_adel), 32'(exp_adel()));
`ifdef PC_HIST_EN
    check_eq("hist_pc", hist_pc, m_hist[hist_idx]);
`endif
  endtask

  task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] rt,
                      input logic ex, input logic er, input logic [31:0] ep);
    reset = rst;
    bus.stall = st; bus.redir_valid = rv; bus.redir_target = rt;
    bus.exc_valid = ex; bus.eret_valid = er; bus.epc = ep;
`ifdef PC_HIST_EN
    hist_idx = 3'($urandom_range(0, 7));
`endif
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) a = $urandom;
    else a = 32'h0000_3000 + (32'($urandom_range(0, 32'h3FFF)) & 32'hFFFF_FFFC);
    return a;
  endfunction

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.redir_valid = 1'b0; bus.redir_target = '0;
    bus.exc_valid = 1'b0; bus.eret_valid = 1'b0; bus.epc = '0;
`ifdef PC_HIST_EN
    hist_idx = 3'd0;
`endif
    // Reset, then ten sequential fetches from the reset vector
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("reset_pc", bus.pc, 32'h0000_3000);
    check_eq("reset_valid", 32'(bus.pc_valid), 32'd0);
    idle();
    check_eq("boot_pc", bus.pc, 32'h0000_3000);
    idle(); idle();
    check_eq("seq_pc", bus.pc, 32'h0000_3008);
    repeat (7) idle();
    check_eq("seq10_pc", bus.pc, 32'h0000_3024);
`ifdef PC_HIST_EN
    hist_idx = 3'd0; #1;
    check_eq("hist_idx0", hist_pc, 32'h0000_3024);
    hist_idx = 3'd7; #1;
    check_eq("hist_idx7", hist_pc, 32'h0000_3008);
`endif
    // Redirect held under stall
    step(1'b0, 1'b0, 1'b1, 32'h0000_3010, 1'b0, 1'b0, 32'h0);
    repeat (3) begin
      step(1'b0, 1'b1, 1'b1, 32'h0000_3100, 1'b0, 1'b0, 32'h0);
      check_eq("hold_pc", bus.pc, 32'h0000_3010);
      check_eq("hold_pend", 32'(bus.redir_pending), 32'd1);
    end
    idle();
    check_eq("release_pc", bus.pc, 32'h0000_3100);
    check_eq("release_pend", 32'(bus.redir_pending), 32'd0);
    // Newer redirect overwrites the held target
    step(1'b0, 1'b1, 1'b1, 32'h0000_3100, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_3200, 1'b0, 1'b0, 32'h0);
    idle();
    check_eq("overwrite_pc", bus.pc, 32'h0000_3200);
    // Exception beats everything, then ERET
    step(1'b0, 1'b1, 1'b1, 32'h0000_3300, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_3400, 1'b1, 1'b1, 32'h0000_3024);
    check_eq("exc_pc", bus.pc, 32'h0000_4180);
    check_eq("exc_pend", 32'(bus.redir_pending), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3024);
    check_eq("eret_pc", bus.pc, 32'h0000_3024);
    idle();
    check_eq("post_eret_pc", bus.pc, 32'h0000_3028);
    // Address-error boundaries
    step(1'b0, 1'b0, 1'b1, 32'h0000_3002, 1'b0, 1'b0, 32'h0);
    check_eq("adel_misalign", 32'(bus.fetch_adel), 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'h0000_7000, 1'b0, 1'b0, 32'h0);
    check_eq("adel_high", 32'(bus.fetch_adel), 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'h0000_6FFC, 1'b0, 1'b0, 32'h0);
    check_eq("adel_top_ok", 32'(bus.fetch_adel), 32'd0);
    idle();
    check_eq("adel_past_top", 32'(bus.fetch_adel), 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'h0000_2FFC, 1'b0, 1'b0, 32'h0);
    check_eq("adel_low", 32'(bus.fetch_adel), 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    idle();
    check_eq("wrap_pc", bus.pc, 32'h0000_0000);
    // Reset in the middle of a held redirect
    step(1'b0, 1'b1, 1'b1, 32'h0000_3500, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    idle(); idle();
    check_eq("rst_hold_pc", bus.pc, 32'h0000_3004);
    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) < 2),
           rand_addr(),
           ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 3),
           rand_addr());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
